// File: rtl/microwave_timer_ctrl_pkg.sv
// Shared definitions for the microwave cooking-sequence controller:
// state encoding, BCD digit layout and the load-value validity rule.
package microwave_timer_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DIGIT_W   = 4;
    localparam int SEC_UNITS = 0;
    localparam int SEC_TENS  = 1;
    localparam int MIN_UNITS = 2;
    localparam int MIN_TENS  = 3;

    localparam logic [3:0] MAX_SEC_TENS = 4'd5;
    localparam logic [3:0] MAX_DIGIT    = 4'd9;

    function automatic logic load_valid(input logic [15:0] value);
        return (value[MIN_TENS*DIGIT_W  +: DIGIT_W] <= MAX_DIGIT)
            && (value[MIN_UNITS*DIGIT_W +: DIGIT_W] <= MAX_DIGIT)
            && (value[SEC_TENS*DIGIT_W  +: DIGIT_W] <= MAX_SEC_TENS)
            && (value[SEC_UNITS*DIGIT_W +: DIGIT_W] <= MAX_DIGIT)
            && (value != 16'h0000);
    endfunction

endpackage

// File: rtl/microwave_timer_ctrl_bcd_digit_down.sv
// One BCD down-counting digit: loadable, wraps 0 -> wrap_limit on decrement,
// and flags borrow whenever it sits at 0 so the next digit can be chained.
module bcd_digit_down (
    input  logic       clock,
    input  logic       clear,
    input  logic       load_en,
    input  logic [3:0] load_value,
    input  logic       dec_en,
    input  logic [3:0] wrap_limit,
    output logic [3:0] digit,
    output logic       borrow
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            digit <= 4'd0;
        end else if (load_en) begin
            digit <= load_value;
        end else if (dec_en) begin
            digit <= (digit == 4'd0) ? wrap_limit : digit - 4'd1;
        end
    end

    assign borrow = (digit == 4'd0);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time controller: BCD mm:ss countdown on a 1 Hz tick,
// start/stop/door pause handling, and a timed end-of-cook beep.
module microwave_timer_ctrl
    import microwave_timer_ctrl_pkg::*;
#(
    parameter int BEEP_TICKS = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        tick_1hz,
    input  logic        start,
    input  logic        stop,
    input  logic        door_open,
    input  logic        load,
    input  logic [15:0] load_time,
    output logic [15:0] time_bcd,
    output logic [2:0]  state,
    output logic        magnetron_on,
    output logic        light_on,
    output logic        beep
);

    localparam logic [3:0] BEEP_LAST = 4'(BEEP_TICKS - 1);

    state_t      cur_state, next_state;
    logic [3:0]  beep_cnt, next_beep_cnt;
    logic        time_load, time_dec;
    logic [15:0] time_value;
    logic [3:0]  dec_en, borrow;
    logic        load_ok, start_ok, time_is_zero, time_is_one;

    assign load_ok      = load && load_valid(load_time);
    assign start_ok     = start && !door_open;
    assign time_is_zero = &borrow;
    assign time_is_one  = (time_bcd == 16'h0001);

    // Each branch lists events in priority order; the first applicable one wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        next_state    = cur_state;
        next_beep_cnt = beep_cnt;
        time_load     = 1'b0;
        time_value    = load_time;
        time_dec      = 1'b0;
        case (cur_state)
            IDLE: begin
                if (load_ok) begin
                    next_state = READY;
                    time_load  = 1'b1;
                end
            end
            READY: begin
                if (stop) begin
                    next_state = IDLE;
                    time_load  = 1'b1;
                    time_value = 16'h0000;
                end else if (start_ok) begin
                    next_state = COOK;
                end else if (load_ok) begin
                    time_load = 1'b1;
                end
            end
            COOK: begin
                if (door_open || stop) begin
                    next_state = PAUSE;
                end else if (tick_1hz && !time_is_zero) begin
                    time_dec = 1'b1;
                    if (time_is_one) begin
                        next_state    = DONE;
                        next_beep_cnt = 4'd0;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    next_state = IDLE;
                    time_load  = 1'b1;
                    time_value = 16'h0000;
                end else if (start_ok) begin
                    next_state = COOK;
                end
            end
            DONE: begin
                if (stop || door_open) begin
                    next_state    = IDLE;
                    next_beep_cnt = 4'd0;
                end else if (tick_1hz) begin
                    if (beep_cnt == BEEP_LAST) begin
                        next_state    = IDLE;
                        next_beep_cnt = 4'd0;
                    end else begin
                        next_beep_cnt = beep_cnt + 4'd1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cur_state <= IDLE;
            beep_cnt  <= 4'd0;
            beep      <= 1'b0;
        end else begin
            cur_state <= next_state;
            beep_cnt  <= next_beep_cnt;
            beep      <= (next_state == DONE);
        end
    end

    // Digit i decrements only when every lower digit is at 0 and borrows.
    for (genvar i = 0; i < 4; i++) begin : g_digit
        localparam logic [3:0] LIMIT = (i == SEC_TENS) ? MAX_SEC_TENS : MAX_DIGIT;

        if (i == 0) begin : g_first
            assign dec_en[i] = time_dec;
        end else begin : g_rest
            assign dec_en[i] = dec_en[i-1] & borrow[i-1];
        end

        bcd_digit_down u_digit (
            .clock      (clock),
            .clear      (clear),
            .load_en    (time_load),
            .load_value (time_value[i*DIGIT_W +: DIGIT_W]),
            .dec_en     (dec_en[i]),
            .wrap_limit (LIMIT),
            .digit      (time_bcd[i*DIGIT_W +: DIGIT_W]),
            .borrow     (borrow[i])
        );
    end

    assign state        = cur_state;
    assign magnetron_on = (cur_state == COOK) && !door_open;
    assign light_on     = door_open || (cur_state == COOK);

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Self-checking bench for microwave_timer_ctrl: directed vector table, corner
// sequences and randomized traffic against a seconds-based reference model.
module tb_microwave_timer_ctrl;

    localparam int BEEP_TICKS = 4;

    logic        clock = 1'b0;
    logic        clear;
    logic        tick_1hz, start, stop, door_open, load;
    logic [15:0] load_time;
    logic [15:0] time_bcd;
    logic [2:0]  state;
    logic        magnetron_on, light_on, beep;

    microwave_timer_ctrl #(.BEEP_TICKS(BEEP_TICKS)) dut (
        .clock        (clock),
        .clear        (clear),
        .tick_1hz     (tick_1hz),
        .start        (start),
        .stop         (stop),
        .door_open    (door_open),
        .load         (load),
        .load_time    (load_time),
        .time_bcd     (time_bcd),
        .state        (state),
        .magnetron_on (magnetron_on),
        .light_on     (light_on),
        .beep         (beep)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference model: remaining time held as plain seconds.
    int m_state = 0;
    int m_secs  = 0;
    int m_beep  = 0;

    function automatic bit model_valid(input logic [15:0] v);
        return (v[15:12] <= 9) && (v[11:8] <= 9) && (v[7:4] <= 5) && (v[3:0] <= 9) && (v != 0);
    endfunction

    function automatic int to_secs(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m, x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic model_step();
        case (m_state)
            0: if (load && model_valid(load_time)) begin m_state = 1; m_secs = to_secs(load_time); end
            1: begin
                if (stop) begin m_state = 0; m_secs = 0; end
                else if (start && !door_open) m_state = 2;
                else if (load && model_valid(load_time)) m_secs = to_secs(load_time);
            end
            2: begin
                if (door_open || stop) m_state = 3;
                else if (tick_1hz) begin
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin m_state = 4; m_beep = 0; end
                end
            end
            3: begin
                if (stop) begin m_state = 0; m_secs = 0; end
                else if (start && !door_open) m_state = 2;
            end
            default: begin
                if (stop || door_open) begin m_state = 0; m_beep = 0; end
                else if (tick_1hz) begin
                    m_beep++;
                    if (m_beep == BEEP_TICKS) begin m_state = 0; m_beep = 0; end
                end
            end
        endcase
    endtask

    task automatic model_reset();
        m_state = 0;
        m_secs  = 0;
        m_beep  = 0;
    endtask

    task automatic check_model(input string name);
        logic [21:0] exp_v, act_v;
        exp_v = {3'(m_state), to_bcd(m_secs), (m_state == 2) && !door_open,
                 door_open || (m_state == 2), m_state == 4};
        act_v = {state, time_bcd, magnetron_on, light_on, beep};
        check(name, 32'(act_v), 32'(exp_v));
    endtask

    // Drive one cycle of inputs, advance model and DUT, sample 1 ns after the edge.
    task automatic cycle(input bit st, input bit sp, input bit dr, input bit ld,
                         input bit tk, input logic [15:0] lt);
        start = st; stop = sp; door_open = dr; load = ld; tick_1hz = tk; load_time = lt;
        model_step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        bit          st, sp, dr, ld, tk;
        logic [15:0] lt;
        logic [2:0]  exp_state;
        logic [15:0] exp_time;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int mag_cnt;

        //            st sp dr ld tk  load_time  state  time
        vecs[0]  = '{0, 0, 0, 1, 0, 16'h0075, 3'd0, 16'h0000};
        vecs[1]  = '{0, 0, 0, 1, 0, 16'h1A00, 3'd0, 16'h0000};
        vecs[2]  = '{0, 0, 0, 1, 0, 16'h0000, 3'd0, 16'h0000};
        vecs[3]  = '{1, 0, 0, 0, 1, 16'h0000, 3'd0, 16'h0000};
        vecs[4]  = '{0, 0, 0, 1, 0, 16'h0005, 3'd1, 16'h0005};
        vecs[5]  = '{1, 0, 1, 0, 0, 16'h0000, 3'd1, 16'h0005};
        vecs[6]  = '{1, 0, 0, 0, 0, 16'h0000, 3'd2, 16'h0005};
        vecs[7]  = '{0, 0, 0, 0, 1, 16'h0000, 3'd2, 16'h0004};
        vecs[8]  = '{0, 0, 1, 0, 1, 16'h0000, 3'd3, 16'h0004};
        vecs[9]  = '{0, 0, 0, 0, 1, 16'h0000, 3'd3, 16'h0004};
        vecs[10] = '{1, 0, 0, 1, 0, 16'h0030, 3'd2, 16'h0004};
        vecs[11] = '{0, 1, 0, 0, 1, 16'h0000, 3'd3, 16'h0004};
        vecs[12] = '{0, 1, 0, 0, 0, 16'h0000, 3'd0, 16'h0000};
        vecs[13] = '{0, 0, 0, 1, 1, 16'h0959, 3'd1, 16'h0959};
        vecs[14] = '{0, 0, 0, 1, 0, 16'h0130, 3'd1, 16'h0130};
        vecs[15] = '{1, 1, 0, 0, 0, 16'h0000, 3'd0, 16'h0000};

        clear = 1'b1;
        {tick_1hz, start, stop, door_open, load} = '0;
        load_time = 16'h0000;
        #12;
        clear = 1'b0;
        @(posedge clock);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_time", 32'(time_bcd), 32'h0000);
        check("reset_magnetron", 32'(magnetron_on), 32'd0);
        check("reset_light", 32'(light_on), 32'd0);
        check("reset_beep", 32'(beep), 32'd0);

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].st, vecs[i].sp, vecs[i].dr, vecs[i].ld, vecs[i].tk, vecs[i].lt);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_time", i), 32'(time_bcd), 32'(vecs[i].exp_time));
            check_model($sformatf("vec%0d_model", i));
        end

        // Full 01:30 cook followed by the beep phase.
        cycle(0, 0, 0, 1, 0, 16'h0130);
        cycle(1, 0, 0, 0, 0, 16'h0000);
        check("cook_start_magnetron", 32'(magnetron_on), 32'd1);
        mag_cnt = 0;
        for (int t = 1; t <= 90; t++) begin
            if (magnetron_on) mag_cnt++;
            cycle(0, 0, 0, 0, 1, 16'h0000);
            check_model($sformatf("cook_tick%0d", t));
            if (t == 30) check("time_0100", 32'(time_bcd), 32'h0100);
            if (t == 31) check("time_0059", 32'(time_bcd), 32'h0059);
            if (t == 89) check("still_cook_t89", 32'(state), 32'd2);
            if (t == 90) begin
                check("done_state", 32'(state), 32'd4);
                check("done_time", 32'(time_bcd), 32'h0000);
                check("done_magnetron", 32'(magnetron_on), 32'd0);
                check("done_beep", 32'(beep), 32'd1);
            end
            cycle(0, 0, 0, 0, 0, 16'h0000);
        end
        check("magnetron_tick_periods", 32'(mag_cnt), 32'd90);
        for (int k = 1; k <= BEEP_TICKS; k++) begin
            cycle(0, 0, 0, 0, 1, 16'h0000);
            check($sformatf("beep_state_k%0d", k), 32'(state), (k < BEEP_TICKS) ? 32'd4 : 32'd0);
            check($sformatf("beep_k%0d", k), 32'(beep), (k < BEEP_TICKS) ? 32'd1 : 32'd0);
            cycle(0, 0, 0, 0, 0, 16'h0000);
        end

        // Borrow chains.
        cycle(0, 0, 0, 1, 0, 16'h1000);
        cycle(1, 0, 0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 16'h0000);
        check("borrow_1000", 32'(time_bcd), 32'h0959);
        cycle(0, 1, 0, 0, 0, 16'h0000);
        cycle(0, 1, 0, 0, 0, 16'h0000);
        check("stop_stop_idle", 32'(state), 32'd0);
        cycle(0, 0, 0, 1, 0, 16'h0100);
        cycle(1, 0, 0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 16'h0000);
        check("borrow_0100", 32'(time_bcd), 32'h0059);

        // Door opens mid-cook: heating drops before the edge, then PAUSE holds time.
        cycle(0, 1, 0, 0, 0, 16'h0000);
        cycle(0, 1, 0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 1, 0, 16'h0010);
        cycle(1, 0, 0, 0, 0, 16'h0000);
        door_open = 1'b1;
        #1;
        check("door_magnetron_same_cycle", 32'(magnetron_on), 32'd0);
        check("door_state_before_edge", 32'(state), 32'd2);
        cycle(0, 0, 1, 0, 0, 16'h0000);
        check("door_pause", 32'(state), 32'd3);
        for (int t = 0; t < 5; t++) cycle(0, 0, 1, 0, 1, 16'h0000);
        check("pause_time_held", 32'(time_bcd), 32'h0010);
        cycle(1, 0, 0, 0, 0, 16'h0000);
        check_model("resume_cook");
        check("resume_time", 32'(time_bcd), 32'h0010);

        // Asynchronous clear in COOK, then in DONE.
        clear = 1'b1;
        #2;
        check("clear_cook", 32'({state, time_bcd, magnetron_on, beep}), 32'h0);
        model_reset();
        #2;
        clear = 1'b0;
        cycle(0, 0, 0, 1, 0, 16'h0001);
        cycle(1, 0, 0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 16'h0000);
        check("done_from_0001", 32'({state, beep}), 32'({3'd4, 1'b1}));
        clear = 1'b1;
        #2;
        check("clear_done", 32'({state, time_bcd, magnetron_on, beep}), 32'h0);
        model_reset();
        #2;
        clear = 1'b0;
        cycle(0, 0, 0, 0, 0, 16'h0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit st, sp, dr, ld, tk;
            logic [15:0] lt;
            dr = ($urandom_range(0, 15) == 0) ? !door_open : door_open;
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 24) == 0);
            ld = ($urandom_range(0, 7) == 0);
            tk = ($urandom_range(0, 1) == 0);
            lt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : to_bcd($urandom_range(0, 40));
            cycle(st, sp, dr, ld, tk, lt);
            check_model($sformatf("random%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
